host_arbiter: RTL and testbench

Shares the single Manta core-chain bus between two host bridges (Ethernet and UART) so both can access cores such as the LUT memory. One transaction is outstanding at a time:
- A request from one bridge is granted and issued onto the chain.
- The arbiter waits for the same transaction to emerge from the chain's end.
- The result is returned to the bridge that issued it.

It sits between the host bridges and the first core in the chain; the chain end loops back into it.

---
 rtl/host_arbiter_pkg.sv | 25 ++
 rtl/host_arbiter_rr_grant.sv | 39 +++
 rtl/host_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_host_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_arbiter_pkg.sv
// Shared types and bus geometry for the host arbiter and the host bridges that
// sit in front of the Manta core chain.
package host_arbiter_pkg;

    localparam int unsigned BUS_ADDR_WIDTH = 16;
    localparam int unsigned BUS_DATA_WIDTH = 16;
    localparam int unsigned BUS_TIMEOUT    = 255;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_t;

    typedef enum logic {
        OWNER_A,
        OWNER_B
    } owner_t;

    function automatic owner_t other_owner(input owner_t owner);
        return (owner == OWNER_A) ? OWNER_B : OWNER_A;
    endfunction

endpackage

// File: rtl/host_arbiter_rr_grant.sv
// Two-requester round-robin grant; the last-served owner only moves when a grant
// is actually taken, so a stalled arbiter never loses its fairness history.
module rr_grant
    import host_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req_a_i,
    input  logic   req_b_i,
    input  logic   accept_i,
    output logic   gnt_valid_o,
    output owner_t gnt_owner_o
);

    owner_t last_q;
    owner_t last_d;

    always_comb begin
        gnt_valid_o = req_a_i | req_b_i;
        if (req_a_i && req_b_i) begin
            gnt_owner_o = other_owner(last_q);
        end else if (req_b_i) begin
            gnt_owner_o = OWNER_B;
        end else begin
            gnt_owner_o = OWNER_A;
        end
        last_d = (accept_i && gnt_valid_o) ? gnt_owner_o : last_q;
    end

    // B counts as last served out of reset so A wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWNER_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/host_arbiter.sv
// Shares the Manta core-chain bus between host bridges A and B: one request at a time
// is issued, its return is awaited at the chain end, and the result goes back to its issuer.
module host_arbiter
    import host_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = BUS_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic                  a_rw_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    output logic [DATA_WIDTH-1:0] a_data_o,
    output logic                  a_rw_o,
    output logic                  a_valid_o,
    output logic                  a_err_o,

    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    input  logic                  b_rw_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    output logic [DATA_WIDTH-1:0] b_data_o,
    output logic                  b_rw_o,
    output logic                  b_valid_o,
    output logic                  b_err_o,

    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_data_o,
    output logic                  bus_rw_o,
    output logic                  bus_valid_o,

    input  logic [ADDR_WIDTH-1:0] bus_addr_i,
    input  logic [DATA_WIDTH-1:0] bus_data_i,
    input  logic                  bus_rw_i,
    input  logic                  bus_valid_i
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rw_q, rw_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  hit_q, hit_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_rw_q, resp_rw_d;
    logic                  resp_err_q, resp_err_d;

    logic   gnt_valid;
    owner_t gnt_owner;
    logic   accept;
    logic   ret_match;
    logic   timed_out;

    rr_grant u_rr_grant (
        .clk         (clk),
        .rst         (rst),
        .req_a_i     (a_valid_i),
        .req_b_i     (b_valid_i),
        .accept_i    (accept),
        .gnt_valid_o (gnt_valid),
        .gnt_owner_o (gnt_owner)
    );

    assign accept    = (state_q == IDLE) && gnt_valid;
    assign a_ready_o = accept && (gnt_owner == OWNER_A);
    assign b_ready_o = accept && (gnt_owner == OWNER_B);

    assign ret_match = bus_valid_i && (bus_addr_i == addr_q);
    assign timed_out = (state_q == WAIT) && !hit_q && (cnt_q == CNT_LIMIT);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rw_d        = rw_q;
        cnt_d       = cnt_q;
        hit_d       = hit_q;
        resp_data_d = resp_data_q;
        resp_rw_d   = resp_rw_q;
        resp_err_d  = resp_err_q;

        unique case (state_q)
            IDLE: begin
                cnt_d      = '0;
                hit_d      = 1'b0;
                resp_err_d = 1'b0;
                if (accept) begin
                    owner_d = gnt_owner;
                    if (gnt_owner == OWNER_B) begin
                        addr_d = b_addr_i;
                        data_d = b_data_i;
                        rw_d   = b_rw_i;
                    end else begin
                        addr_d = a_addr_i;
                        data_d = a_data_i;
                        rw_d   = a_rw_i;
                    end
                    state_d = ISSUE;
                end
            end

            // A zero-latency chain returns while the request is still on the bus.
            ISSUE: begin
                if (ret_match) begin
                    hit_d       = 1'b1;
                    resp_data_d = bus_data_i;
                    resp_rw_d   = bus_rw_i;
                end
                state_d = WAIT;
            end

            WAIT: begin
                if (hit_q) begin
                    state_d = RESPOND;
                end else if (timed_out) begin
                    resp_data_d = '0;
                    resp_rw_d   = rw_q;
                    resp_err_d  = 1'b1;
                    state_d     = RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (ret_match) begin
                        hit_d       = 1'b1;
                        resp_data_d = bus_data_i;
                        resp_rw_d   = bus_rw_i;
                    end
                end
            end

            RESPOND: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_A;
            addr_q      <= '0;
            data_q      <= '0;
            rw_q        <= 1'b0;
            cnt_q       <= '0;
            hit_q       <= 1'b0;
            resp_data_q <= '0;
            resp_rw_q   <= 1'b0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rw_q        <= rw_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            resp_data_q <= resp_data_d;
            resp_rw_q   <= resp_rw_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // Bus and response outputs are gated by state so idle lanes always read as zero.
    always_comb begin
        bus_valid_o = 1'b0;
        bus_addr_o  = '0;
        bus_data_o  = '0;
        bus_rw_o    = 1'b0;
        a_valid_o   = 1'b0;
        a_data_o    = '0;
        a_rw_o      = 1'b0;
        a_err_o     = 1'b0;
        b_valid_o   = 1'b0;
        b_data_o    = '0;
        b_rw_o      = 1'b0;
        b_err_o     = 1'b0;

        if (state_q == ISSUE) begin
            bus_valid_o = 1'b1;
            bus_addr_o  = addr_q;
            bus_data_o  = data_q;
            bus_rw_o    = rw_q;
        end

        if (state_q == RESPOND) begin
            if (owner_q == OWNER_A) begin
                a_valid_o = 1'b1;
                a_data_o  = resp_data_q;
                a_rw_o    = resp_rw_q;
                a_err_o   = resp_err_q;
            end else begin
                b_valid_o = 1'b1;
                b_data_o  = resp_data_q;
                b_rw_o    = resp_rw_q;
                b_err_o   = resp_err_q;
            end
        end
    end

endmodule

// File: tb/tb_host_arbiter.sv
// Bench for host_arbiter: a delay-line chain model feeds returns back, and a
// transaction-level model predicts grants, bus issues and responses cycle by cycle.
module tb_host_arbiter;
    import host_arbiter_pkg::*;

    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 16;
    localparam int unsigned TMO  = 8;
    localparam int          PIPE = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] a_addr_i, b_addr_i, bus_addr_o, bus_addr_i;
    logic [DW-1:0] a_data_i, b_data_i, a_data_o, b_data_o, bus_data_o, bus_data_i;
    logic a_rw_i, a_valid_i, a_ready_o, a_rw_o, a_valid_o, a_err_o;
    logic b_rw_i, b_valid_i, b_ready_o, b_rw_o, b_valid_o, b_err_o;
    logic bus_rw_o, bus_valid_o, bus_rw_i, bus_valid_i;

    host_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_rw_i(a_rw_i), .a_valid_i(a_valid_i),
        .a_ready_o(a_ready_o), .a_data_o(a_data_o), .a_rw_o(a_rw_o), .a_valid_o(a_valid_o),
        .a_err_o(a_err_o),
        .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_rw_i(b_rw_i), .b_valid_i(b_valid_i),
        .b_ready_o(b_ready_o), .b_data_o(b_data_o), .b_rw_o(b_rw_o), .b_valid_o(b_valid_o),
        .b_err_o(b_err_o),
        .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_rw_o(bus_rw_o),
        .bus_valid_o(bus_valid_o),
        .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i), .bus_rw_i(bus_rw_i),
        .bus_valid_i(bus_valid_i)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core chain model: reads return addr ^ 0xBEEC (so 0x0003 -> 0xBEEF), writes echo.
    function automatic logic [DW-1:0] core_read(input logic [AW-1:0] a);
        return DW'(a) ^ 16'hBEEC;
    endfunction

    int            chain_lat = 0;
    bit            chain_on  = 1'b1;
    logic          inj_en    = 1'b0;
    logic [AW-1:0] inj_addr  = '0;
    logic [DW-1:0] inj_data  = '0;
    logic          inj_rw    = 1'b0;

    logic          pv [PIPE];
    logic [AW-1:0] pa [PIPE];
    logic [DW-1:0] pd [PIPE];
    logic          pr [PIPE];

    always @(posedge clk) begin
        pv[0] <= (bus_valid_o === 1'b1) && chain_on;
        pa[0] <= bus_addr_o;
        pd[0] <= bus_rw_o ? bus_data_o : core_read(bus_addr_o);
        pr[0] <= bus_rw_o;
        for (int i = 1; i < PIPE; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
            pd[i] <= pd[i-1];
            pr[i] <= pr[i-1];
        end
    end

    always_comb begin
        bus_valid_i = 1'b0;
        bus_addr_i  = '0;
        bus_data_i  = '0;
        bus_rw_i    = 1'b0;
        if (inj_en) begin
            bus_valid_i = 1'b1;
            bus_addr_i  = inj_addr;
            bus_data_i  = inj_data;
            bus_rw_i    = inj_rw;
        end else if (chain_lat == 0) begin
            bus_valid_i = bus_valid_o && chain_on;
            bus_addr_i  = bus_addr_o;
            bus_data_i  = bus_rw_o ? bus_data_o : core_read(bus_addr_o);
            bus_rw_i    = bus_rw_o;
        end else begin
            bus_valid_i = pv[chain_lat-1];
            bus_addr_i  = pa[chain_lat-1];
            bus_data_i  = pd[chain_lat-1];
            bus_rw_i    = pr[chain_lat-1];
        end
    end

    // Reference model state.
    typedef struct {
        int            cyc;
        bit            is_b;
        logic [DW-1:0] data;
        logic          rw;
        logic          err;
    } resp_t;
    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          rw;
    } issue_t;

    resp_t  resp_q[$];
    issue_t issue_q[$];
    bit     grant_log[$];
    bit     auto_expect = 1'b1;
    bit     last_b      = 1'b1;
    int     next_free   = 0;
    int     resp_seen   = 0;

    initial begin : monitor
        bit              idle, exp_ra, exp_rb, is_b, ok;
        logic [AW-1:0]   m_addr;
        logic [DW-1:0]   m_data;
        logic            m_rw;
        logic [2*DW+5:0] exp_vec;
        forever begin
            @(negedge clk);
            if (rst) begin
                resp_q.delete();
                issue_q.delete();
                last_b    = 1'b1;
                next_free = 0;
            end else begin
                idle   = (cyc >= next_free);
                exp_ra = idle && a_valid_i && (!b_valid_i || last_b);
                exp_rb = idle && b_valid_i && (!a_valid_i || !last_b);
                check("ready", {a_ready_o, b_ready_o}, {exp_ra, exp_rb});

                if ((a_valid_i && a_ready_o) || (b_valid_i && b_ready_o)) begin
                    is_b   = b_valid_i && b_ready_o;
                    m_addr = is_b ? b_addr_i : a_addr_i;
                    m_data = is_b ? b_data_i : a_data_i;
                    m_rw   = is_b ? b_rw_i : a_rw_i;
                    last_b = is_b;
                    grant_log.push_back(is_b);
                    next_free = 32'h3fff_ffff;
                    issue_q.push_back('{cyc + 1, m_addr, m_data, m_rw});
                    if (auto_expect) begin
                        ok = chain_on && (chain_lat <= int'(TMO));
                        resp_q.push_back('{ok ? cyc + 3 + chain_lat : cyc + 3 + int'(TMO), is_b,
                                           ok ? (m_rw ? m_data : core_read(m_addr)) : '0,
                                           m_rw, !ok});
                    end
                end

                if (issue_q.size() > 0 && issue_q[0].cyc == cyc) begin
                    check("issue", {bus_valid_o, bus_addr_o, bus_data_o, bus_rw_o},
                          {1'b1, issue_q[0].addr, issue_q[0].data, issue_q[0].rw});
                    void'(issue_q.pop_front());
                end else begin
                    check("bus_quiet", {bus_valid_o, bus_addr_o, bus_data_o, bus_rw_o}, '0);
                end

                if (a_valid_o || b_valid_o) resp_seen++;
                if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
                    if (resp_q[0].is_b) begin
                        exp_vec = {1'b0, {DW{1'b0}}, 1'b0, 1'b0,
                                   1'b1, resp_q[0].data, resp_q[0].rw, resp_q[0].err};
                    end else begin
                        exp_vec = {1'b1, resp_q[0].data, resp_q[0].rw, resp_q[0].err,
                                   1'b0, {DW{1'b0}}, 1'b0, 1'b0};
                    end
                    check("resp", {a_valid_o, a_data_o, a_rw_o, a_err_o,
                                   b_valid_o, b_data_o, b_rw_o, b_err_o}, exp_vec);
                    void'(resp_q.pop_front());
                    next_free = cyc + 1;
                end else begin
                    check("no_resp", {a_valid_o, b_valid_o}, 2'b00);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic request(input bit is_b, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic rw);
        bit got;
        got = 1'b0;
        if (is_b) begin
            b_addr_i = addr; b_data_i = data; b_rw_i = rw; b_valid_i = 1'b1;
        end else begin
            a_addr_i = addr; a_data_i = data; a_rw_i = rw; a_valid_i = 1'b1;
        end
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            got = is_b ? b_ready_o : a_ready_o;
        end
        step();
        if (is_b) b_valid_i = 1'b0;
        else a_valid_i = 1'b0;
        check("accept_bound", got, 1'b1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (resp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check("drain", resp_q.size(), 0);
    endtask

    initial begin : stimulus
        int            c0, mode;
        logic [AW-1:0] ra, rb;
        logic [DW-1:0] da, db;
        logic          wa, wb;

        rst = 1'b1;
        a_addr_i = '0; a_data_i = '0; a_rw_i = 1'b0; a_valid_i = 1'b0;
        b_addr_i = '0; b_data_i = '0; b_rw_i = 1'b0; b_valid_i = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("reset_outputs", {a_ready_o, b_ready_o, a_valid_o, a_data_o, a_rw_o, a_err_o,
                                b_valid_o, b_data_o, b_rw_o, b_err_o,
                                bus_valid_o, bus_addr_o, bus_data_o, bus_rw_o}, '0);
        rst = 1'b0;

        // Tie from reset: both bridges queue three requests each.
        grant_log.delete();
        chain_lat = 1;
        fork
            begin
                for (int i = 0; i < 3; i++) request(1'b0, AW'(32'h0100 + i), DW'(32'h0a00 + i), 1'b0);
            end
            begin
                for (int i = 0; i < 3; i++) request(1'b1, AW'(32'h0200 + i), DW'(32'h0b00 + i), 1'b1);
            end
        join
        wait_done();
        check("tie_count", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) check("tie_order", grant_log[i], i % 2);

        // Read through a 2-cycle chain, then a B write.
        chain_lat = 2;
        request(1'b0, 16'h0003, 16'h0000, 1'b0);
        wait_done();
        chain_lat = 1;
        request(1'b1, 16'h0007, 16'h1234, 1'b1);
        wait_done();

        // Latency right at the timeout edge, then one cycle beyond it.
        chain_lat = int'(TMO);
        request(1'b0, 16'h0030, 16'h0000, 1'b0);
        wait_done();
        chain_lat = int'(TMO) + 1;
        request(1'b1, 16'h0031, 16'h5555, 1'b1);
        wait_done();

        // Chain never answers; a stray return afterwards must be ignored.
        chain_on = 1'b0;
        request(1'b0, 16'h0005, 16'h0000, 1'b0);
        wait_done();
        c0 = resp_seen;
        inj_addr = 16'h0005; inj_data = 16'hAAAA; inj_rw = 1'b0; inj_en = 1'b1;
        step();
        inj_en = 1'b0;
        repeat (4) step();
        check("stray_ignored", resp_seen, c0);

        // Wrong-address return first, correct one two cycles later.
        auto_expect = 1'b0;
        request(1'b0, 16'h0010, 16'h0000, 1'b0);
        step();
        step();
        inj_addr = 16'h0011; inj_data = 16'hDEAD; inj_en = 1'b1;
        step();
        inj_en = 1'b0;
        step();
        resp_q.push_back('{cyc + 2, 1'b0, 16'h7777, 1'b0, 1'b0});
        inj_addr = 16'h0010; inj_data = 16'h7777; inj_en = 1'b1;
        step();
        inj_en = 1'b0;
        wait_done();
        auto_expect = 1'b1;
        chain_on    = 1'b1;

        // Reset while waiting on a slow chain.
        chain_lat = 4;
        request(1'b0, 16'h0020, 16'h0000, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_outputs", {a_ready_o, b_ready_o, a_valid_o, a_data_o, a_rw_o, a_err_o,
                              b_valid_o, b_data_o, b_rw_o, b_err_o,
                              bus_valid_o, bus_addr_o, bus_data_o, bus_rw_o}, '0);
        check("rst_state", dut.state_q, IDLE);
        step();
        c0 = cyc;
        request(1'b0, 16'h0040, 16'h0000, 1'b0);
        check("rst_accept_lat", cyc - c0, 1);
        wait_done();

        // Random traffic against the model.
        for (int k = 0; k < 30; k++) begin
            chain_lat = int'($urandom_range(0, 5));
            mode = int'($urandom_range(0, 2));
            ra = AW'($urandom()); da = DW'($urandom()); wa = 1'($urandom());
            rb = AW'($urandom()); db = DW'($urandom()); wb = 1'($urandom());
            if (mode == 0) begin
                request(1'b0, ra, da, wa);
            end else if (mode == 1) begin
                request(1'b1, rb, db, wb);
            end else begin
                fork
                    request(1'b0, ra, da, wa);
                    request(1'b1, rb, db, wb);
                join
            end
            wait_done();
        end

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
